// File: rtl/hdmi_timing_sequencer.sv
// HDMI raster sequencer: power-up hold, frame counters, sync/DE decode and scaled source addressing.
// Optional build macro AUDIO_TICK_EN adds a 48 kHz strobe derived from the pixel clock.
module hdmi_timing_sequencer #(
  parameter int FRAMEWIDTH    = 720,
  parameter int FRAMEHEIGHT   = 480,
  parameter int TOTALWIDTH    = 858,
  parameter int TOTALHEIGHT   = 525,
  parameter int HSYNC_START   = 736,
  parameter int HSYNC_LEN     = 62,
  parameter int VSYNC_START   = 489,
  parameter int VSYNC_LEN     = 6,
  parameter int SYNC_POL      = 0,
  parameter int SRC_WIDTH     = 256,
  parameter int SRC_HEIGHT    = 240,
  parameter int SCALE         = 2,
  parameter int POWERUPCYCLES = 2700000,
  parameter int CLKFRQ        = 27000
) (
  input  logic       clk_pixel,
  input  logic       resetn,
  input  logic       enable,
  output logic       ready,
  output logic       running,
  output logic [9:0] cx,
  output logic [9:0] cy,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       src_valid,
  output logic [8:0] src_x,
  output logic [7:0] src_y,
  output logic       audio_tick
);

  if (SRC_WIDTH * SCALE > FRAMEWIDTH || SRC_HEIGHT * SCALE > FRAMEHEIGHT) begin : g_bad_window
    $error("hdmi_timing_sequencer: scaled source does not fit inside the active frame");
  end
  if (CLKFRQ <= 0) begin : g_bad_clkfrq
    $error("hdmi_timing_sequencer: CLKFRQ must be positive");
  end

  localparam int SUBW = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [9:0]      TW_LAST  = 10'(TOTALWIDTH - 1);
  localparam logic [9:0]      TH_LAST  = 10'(TOTALHEIGHT - 1);
  localparam logic [9:0]      FW       = 10'(FRAMEWIDTH);
  localparam logic [9:0]      FH       = 10'(FRAMEHEIGHT);
  localparam logic [9:0]      XOFF     = 10'((FRAMEWIDTH - SRC_WIDTH * SCALE) / 2);
  localparam logic [9:0]      YOFF     = 10'((FRAMEHEIGHT - SRC_HEIGHT * SCALE) / 2);
  localparam logic [10:0]     XSPAN    = 11'(SRC_WIDTH * SCALE);
  localparam logic [10:0]     YSPAN    = 11'(SRC_HEIGHT * SCALE);
  localparam logic [21:0]     DLY_LAST = 22'(POWERUPCYCLES - 1);
  localparam logic [SUBW-1:0] SUB_LAST = SUBW'(SCALE - 1);
  localparam logic            SYNC_ON  = (SYNC_POL != 0);

  typedef enum logic [1:0] {POWERUP, IDLE, RUN, DRAIN} state_t;

  state_t          state, state_n;
  logic [21:0]     dly;
  logic [SUBW-1:0] subx, suby, subx_n, suby_n;
  logic [9:0]      cx_n, cy_n;
  logic [8:0]      sx_n;
  logic [7:0]      sy_n;
  logic [10:0]     hs_off, vs_off, wx_off, wy_off;
  logic            run_n, de_n, hs_n, vs_n, fs_n, win_n, last_px;

  assign last_px = (cx == TW_LAST) && (cy == TH_LAST);

  always_ff @(posedge clk_pixel) begin
    if (!resetn) state <= POWERUP;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      POWERUP: if (dly == DLY_LAST) state_n = IDLE;
      IDLE:    if (enable) state_n = RUN;
      RUN:     if (!enable) state_n = DRAIN;
      DRAIN: begin
        if (enable)       state_n = RUN;
        else if (last_px) state_n = IDLE;
      end
      default: state_n = POWERUP;
    endcase
  end

  // Everything below is computed for the pixel being registered next, so
  // the position and all decodes leave the flops aligned to the same pixel.
  always_comb begin
    cx_n = '0;
    cy_n = '0;
    if (state == RUN || state == DRAIN) begin
      if (cx == TW_LAST) begin
        cx_n = '0;
        cy_n = (cy == TH_LAST) ? '0 : cy + 10'd1;
      end else begin
        cx_n = cx + 10'd1;
        cy_n = cy;
      end
    end
    run_n  = (state_n == RUN) || (state_n == DRAIN);
    hs_off = 11'(cx_n) - 11'(HSYNC_START);
    vs_off = 11'(cy_n) - 11'(VSYNC_START);
    wx_off = 11'(cx_n) - 11'(XOFF);
    wy_off = 11'(cy_n) - 11'(YOFF);
    de_n   = run_n && (cx_n < FW) && (cy_n < FH);
    hs_n   = (run_n && hs_off < 11'(HSYNC_LEN)) ? SYNC_ON : ~SYNC_ON;
    vs_n   = (run_n && vs_off < 11'(VSYNC_LEN)) ? SYNC_ON : ~SYNC_ON;
    fs_n   = run_n && (cx_n == '0) && (cy_n == '0);
    win_n  = run_n && (wx_off < XSPAN) && (wy_off < YSPAN);

    sx_n   = src_x;
    sy_n   = src_y;
    subx_n = subx;
    suby_n = suby;
    // Rows advance once per window line, at that line's left-edge pixel.
    if (win_n) begin
      if (cx_n == XOFF) begin
        sx_n   = '0;
        subx_n = '0;
        if (cy_n == YOFF) begin
          sy_n   = '0;
          suby_n = '0;
        end else if (suby == SUB_LAST) begin
          sy_n   = src_y + 8'd1;
          suby_n = '0;
        end else begin
          suby_n = suby + SUBW'(1);
        end
      end else if (subx == SUB_LAST) begin
        sx_n   = src_x + 9'd1;
        subx_n = '0;
      end else begin
        subx_n = subx + SUBW'(1);
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      dly         <= '0;
      ready       <= 1'b0;
      running     <= 1'b0;
      cx          <= '0;
      cy          <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      frame_start <= 1'b0;
      src_valid   <= 1'b0;
      src_x       <= '0;
      src_y       <= '0;
      subx        <= '0;
      suby        <= '0;
    end else begin
      if (state == POWERUP) begin
        if (dly == DLY_LAST) ready <= 1'b1;
        else                 dly   <= dly + 22'd1;
      end
      running     <= run_n;
      cx          <= cx_n;
      cy          <= cy_n;
      de          <= de_n;
      hsync       <= hs_n;
      vsync       <= vs_n;
      frame_start <= fs_n;
      src_valid   <= win_n;
      src_x       <= sx_n;
      src_y       <= sy_n;
      subx        <= subx_n;
      suby        <= suby_n;
    end
  end

`ifdef AUDIO_TICK_EN
  logic [15:0] acc;
  logic [16:0] acc_sum;

  assign acc_sum = {1'b0, acc} + 17'd48;

  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      acc        <= '0;
      audio_tick <= 1'b0;
    end else begin
      audio_tick <= 1'b0;
      if (ready) begin
        if (acc_sum >= 17'(CLKFRQ)) begin
          acc        <= 16'(acc_sum - 17'(CLKFRQ));
          audio_tick <= 1'b1;
        end else begin
          acc <= acc_sum[15:0];
        end
      end
    end
  end
`else
  assign audio_tick = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_timing_sequencer.sv
// Self-checking bench for hdmi_timing_sequencer on a reduced raster, against a linear-position model.
module tb_hdmi_timing_sequencer;

  localparam int FW = 40, FH = 24, TW = 50, TH = 30;
  localparam int HS = 42, HL = 4, VS = 26, VL = 2, POL = 0;
  localparam int SW = 9, SH = 5, SC = 3, PU = 100, CK = 27000;
  localparam int FRAME = TW * TH;
  localparam int XOFF = (FW - SW * SC) / 2;
  localparam int YOFF = (FH - SH * SC) / 2;
  localparam int XEND = XOFF + SW * SC;
  localparam int YEND = YOFF + SH * SC;
  localparam logic POL_ON = (POL != 0);
  localparam logic [44:0] RESET_VEC = {1'b0, 1'b0, 10'd0, 10'd0, 1'b0, ~POL_ON, ~POL_ON,
                                       1'b0, 1'b0, 9'd0, 8'd0, 1'b0};

  logic clk = 1'b0, resetn = 1'b0, enable = 1'b0;
  logic ready, running, de, hsync, vsync, frame_start, src_valid, audio_tick;
  logic [9:0] cx, cy;
  logic [8:0] src_x;
  logic [7:0] src_y;
  logic [44:0] dut_vec;

  int checks = 0, fails = 0;

  // model: 0 powering up, 1 idle, 2 run, 3 drain; position kept as a linear pixel index
  int m_mode = 0, m_dly = 0, m_pos = 0, m_acc = 0;
  logic m_ready = 1'b0, m_tick = 1'b0;
  logic [8:0] m_sx = '0;
  logic [7:0] m_sy = '0;

  hdmi_timing_sequencer #(
    .FRAMEWIDTH(FW), .FRAMEHEIGHT(FH), .TOTALWIDTH(TW), .TOTALHEIGHT(TH),
    .HSYNC_START(HS), .HSYNC_LEN(HL), .VSYNC_START(VS), .VSYNC_LEN(VL),
    .SYNC_POL(POL), .SRC_WIDTH(SW), .SRC_HEIGHT(SH), .SCALE(SC),
    .POWERUPCYCLES(PU), .CLKFRQ(CK)
  ) dut (
    .clk_pixel(clk), .resetn(resetn), .enable(enable), .ready(ready), .running(running),
    .cx(cx), .cy(cy), .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .src_valid(src_valid), .src_x(src_x), .src_y(src_y), .audio_tick(audio_tick)
  );

  always #5 clk = ~clk;

  assign dut_vec = {ready, running, cx, cy, de, hsync, vsync, frame_start, src_valid,
                    src_x, src_y, audio_tick};

  function automatic logic [44:0] exp_vec();
    int cxv, cyv;
    logic run, win, hs, vs, dv, fs;
    cxv = m_pos % TW;
    cyv = m_pos / TW;
    run = (m_mode >= 2);
    win = run && cxv >= XOFF && cxv < XEND && cyv >= YOFF && cyv < YEND;
    hs  = (run && cxv >= HS && cxv < HS + HL) ? POL_ON : ~POL_ON;
    vs  = (run && cyv >= VS && cyv < VS + VL) ? POL_ON : ~POL_ON;
    dv  = run && cxv < FW && cyv < FH;
    fs  = run && m_pos == 0;
    return {m_ready, run, 10'(cxv), 10'(cyv), dv, hs, vs, fs, win, m_sx, m_sy, m_tick};
  endfunction

  function automatic void model_step();
    int cxv, cyv;
    logic last;
    if (!resetn) begin
      m_mode = 0; m_dly = 0; m_pos = 0; m_acc = 0;
      m_ready = 1'b0; m_tick = 1'b0; m_sx = '0; m_sy = '0;
    end else begin
`ifdef AUDIO_TICK_EN
      m_tick = 1'b0;
      if (m_ready) begin
        m_acc += 48;
        if (m_acc >= CK) begin
          m_acc -= CK;
          m_tick = 1'b1;
        end
      end
`endif
      case (m_mode)
        0: if (m_dly == PU - 1) begin m_ready = 1'b1; m_mode = 1; end else m_dly++;
        1: begin m_pos = 0; if (enable) m_mode = 2; end
        2: begin m_pos = (m_pos + 1) % FRAME; if (!enable) m_mode = 3; end
        default: begin
          last  = (m_pos == FRAME - 1);
          m_pos = (m_pos + 1) % FRAME;
          if (enable) m_mode = 2;
          else if (last) m_mode = 1;
        end
      endcase
      cxv = m_pos % TW;
      cyv = m_pos / TW;
      if (m_mode >= 2 && cxv >= XOFF && cxv < XEND && cyv >= YOFF && cyv < YEND) begin
        m_sx = 9'((cxv - XOFF) / SC);
        m_sy = 8'((cyv - YOFF) / SC);
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_pos(input int target, input string tag);
    bit hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      cycle();
      if (m_mode >= 2 && m_pos == target) hit = 1;
    end
    checks++;
    if (!hit) begin
      fails++;
      $display("FAIL wait_%s timeout got=not reached exp=pos %0d", tag, target);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (dut_vec !== RESET_VEC) begin
        fails++;
        $display("FAIL reset_values got=%h exp=%h", dut_vec, RESET_VEC);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL reset_vec got=%h exp=%h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_powerup();
    resetn = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= PU + 1; i++) begin
      cycle();
      checks++;
      if (ready !== (i >= PU)) begin
        fails++;
        $display("FAIL powerup_ready edge=%0d got=%b exp=%b", i, ready, i >= PU);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL powerup_vec edge=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (frame_start !== 1'b1 || running !== 1'b1 || cx !== 10'd0 || cy !== 10'd0) begin
      fails++;
      $display("FAIL first_run got=fs%b run%b cx%0d cy%0d exp=fs1 run1 cx0 cy0",
               frame_start, running, cx, cy);
    end
  endtask

  task automatic test_frames();
    int fs_at[$];
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0;
    enable = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL frames_vec i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (frame_start) fs_at.push_back(i);
      if (fs_at.size() == 1) begin
        de_cnt += int'(de);
        hs_cnt += int'(hsync == POL_ON);
        vs_cnt += int'(vsync == POL_ON);
      end
    end
    checks++;
    if (fs_at.size() != 2 || fs_at[1] - fs_at[0] != FRAME) begin
      fails++;
      $display("FAIL frame_period got=%0d pulses exp=2 pulses %0d apart", fs_at.size(), FRAME);
    end
    checks++;
    if (de_cnt != FW * FH) begin
      fails++;
      $display("FAIL de_count got=%0d exp=%0d", de_cnt, FW * FH);
    end
    checks++;
    if (hs_cnt != HL * TH) begin
      fails++;
      $display("FAIL hsync_count got=%0d exp=%0d", hs_cnt, HL * TH);
    end
    checks++;
    if (vs_cnt != VL * TW) begin
      fails++;
      $display("FAIL vsync_count got=%0d exp=%0d", vs_cnt, VL * TW);
    end
  endtask

  task automatic test_window();
    int cxv, cyv;
    enable = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      cxv = m_pos % TW;
      cyv = m_pos / TW;
      if (cyv == YOFF && cxv == XOFF - 1) begin
        checks++;
        if (src_valid !== 1'b0) begin
          fails++; $display("FAIL win_before_left got=%b exp=0", src_valid);
        end
      end
      if (cyv == YOFF && cxv == XOFF) begin
        checks++;
        if (src_valid !== 1'b1 || src_x !== 9'd0 || src_y !== 8'd0) begin
          fails++; $display("FAIL win_first got=v%b x%0d y%0d exp=v1 x0 y0", src_valid, src_x, src_y);
        end
      end
      if (cyv == YOFF && cxv == XOFF + SC) begin
        checks++;
        if (src_x !== 9'd1) begin
          fails++; $display("FAIL win_x1 got=%0d exp=1", src_x);
        end
      end
      if (cyv == YOFF && cxv == XEND - 1) begin
        checks++;
        if (src_x !== 9'(SW - 1)) begin
          fails++; $display("FAIL win_xlast got=%0d exp=%0d", src_x, SW - 1);
        end
      end
      if (cyv == YOFF && cxv == XEND) begin
        checks++;
        if (src_valid !== 1'b0 || src_x !== 9'(SW - 1)) begin
          fails++; $display("FAIL win_after_right got=v%b x%0d exp=v0 x%0d", src_valid, src_x, SW - 1);
        end
      end
      if (cyv == YOFF + SC && cxv == XOFF) begin
        checks++;
        if (src_y !== 8'd1) begin
          fails++; $display("FAIL win_y1 got=%0d exp=1", src_y);
        end
      end
      if (cyv == YEND - 1 && cxv == XEND - 1) begin
        checks++;
        if (src_y !== 8'(SH - 1) || src_valid !== 1'b1) begin
          fails++; $display("FAIL win_corner got=v%b y%0d exp=v1 y%0d", src_valid, src_y, SH - 1);
        end
      end
    end
  endtask

  task automatic test_drain();
    int lx = -1, ly = -1;
    bit fell = 0;
    enable = 1'b1;
    wait_pos(10 * TW, "drain_start");
    enable = 1'b0;
    for (int i = 0; i < 2 * FRAME && !fell; i++) begin
      lx = int'(cx);
      ly = int'(cy);
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL drain_vec i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (running === 1'b0) fell = 1;
    end
    checks++;
    if (!fell || lx != TW - 1 || ly != TH - 1) begin
      fails++; $display("FAIL drain_end got=fell%0d cx%0d cy%0d exp=fell1 cx%0d cy%0d", fell, lx, ly, TW - 1, TH - 1);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (cx !== 10'd0 || cy !== 10'd0 || running !== 1'b0 || de !== 1'b0) begin
        fails++; $display("FAIL idle_hold got=cx%0d cy%0d run%b de%b exp=0 0 0 0", cx, cy, running, de);
      end
    end
    enable = 1'b1;
    wait_pos(10 * TW, "redrain_start");
    enable = 1'b0;
    wait_pos(20 * TW, "reassert");
    enable = 1'b1;
    while (m_pos != 0) begin
      cycle();
      checks++;
      if (running !== 1'b1 || dut_vec !== exp_vec()) begin
        fails++; $display("FAIL reassert_vec got=%h exp=%h", dut_vec, exp_vec());
      end
    end
    checks++;
    if (frame_start !== 1'b1) begin
      fails++; $display("FAIL reassert_fs got=%b exp=1", frame_start);
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    enable = 1'b1;
    wait_pos(12 * TW + 20, "midframe");
    resetn = 1'b0;
    cycle();
    checks++;
    if (dut_vec !== RESET_VEC) begin
      fails++; $display("FAIL midreset_values got=%h exp=%h", dut_vec, RESET_VEC);
    end
    resetn = 1'b1;
    while (ready !== 1'b1 && n < PU + 10) begin
      cycle();
      n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL midreset_vec n=%0d got=%h exp=%h", n, dut_vec, exp_vec());
      end
    end
    checks++;
    if (n != PU) begin
      fails++; $display("FAIL midreset_powerup got=%0d edges exp=%0d", n, PU);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      resetn = ($urandom_range(0, 1999) != 0);
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL random_vec i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    resetn = 1'b1;
  endtask

  task automatic test_audio();
    int ticks = 0, last = -1, n = 0;
    resetn = 1'b0;
    enable = 1'b0;
    cycle();
    resetn = 1'b1;
    while (ready !== 1'b1 && n < PU + 10) begin
      cycle();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      fails++; $display("FAIL audio_ready got=%b exp=1", ready);
    end
`ifdef AUDIO_TICK_EN
    for (int i = 1; i <= CK; i++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL audio_vec i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (audio_tick === 1'b1) begin
        ticks++;
        if (last >= 0) begin
          checks++;
          if (i - last != 562 && i - last != 563) begin
            fails++; $display("FAIL audio_interval got=%0d exp=562 or 563", i - last);
          end
        end
        last = i;
      end
    end
    checks++;
    if (ticks != 48) begin
      fails++; $display("FAIL audio_count got=%0d exp=48", ticks);
    end
`else
    for (int i = 0; i < 600; i++) begin
      cycle();
      ticks += int'(audio_tick !== 1'b0);
    end
    checks++;
    if (ticks != 0) begin
      fails++; $display("FAIL audio_tied got=%0d ticks exp=0", ticks);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_frames();
    test_window();
    test_drain();
    test_reset_midframe();
    test_random();
    test_audio();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=bench completion");
    $fatal(1, "bench did not complete");
  end

endmodule
